// File: rtl/echo_tap_scheduler_pkg.sv
// Shared types, default widths and the output fold/saturate helper for the echo tap scheduler.
package echo_pkg;

    localparam int unsigned ADDR_W_DEF = 13;
    localparam int unsigned DATA_W_DEF = 10;
    localparam int unsigned ACC_EXTRA  = 4;
    localparam int unsigned DELAY_W    = 9;

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_WRITE
    } state_e;

    // Clamp to a signed width-bit range when sat_en, else pass through for the caller to truncate.
    function automatic logic signed [31:0] fold_sample(input logic signed [31:0] sum,
                                                       input int unsigned        width,
                                                       input bit                 sat_en);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (width - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (width - 1));
        if (sat_en && (sum > hi)) return hi;
        if (sat_en && (sum < lo)) return lo;
        return sum;
    endfunction

endpackage

// File: rtl/echo_tap_scheduler_if.sv
// Delay-line RAM port bundle: scheduler owns addresses and write strobe, RAM returns read data.
interface echo_tap_scheduler_if #(
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned DATA_W = 10
);
    logic [ADDR_W-1:0] ram_raddr;
    logic [DATA_W-2:0] ram_rdata;
    logic [ADDR_W-1:0] ram_waddr;
    logic              ram_we;
    logic [DATA_W-2:0] ram_wdata;

    modport master (output ram_raddr, ram_waddr, ram_we, ram_wdata, input ram_rdata);
    modport slave  (input ram_raddr, ram_waddr, ram_we, ram_wdata, output ram_rdata);
endinterface

// File: rtl/echo_tap_scheduler_strobe_det.sv
// Two-flop synchroniser on the ADC ready level plus a registered rising-edge strobe.
module echo_strobe_det (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic strobe_o
);
    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic strobe_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            prev_q   <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            sync1_q  <= async_i;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            strobe_q <= sync2_q & ~prev_q;
        end
    end

    assign strobe_o = strobe_q;
endmodule

// File: rtl/echo_tap_scheduler.sv
// Multi-tap echo sequencer: clears the delay line, then per strobe reads NTAPS taps and writes y.
// ECHO_SATURATE_EN selects clamping of y instead of two's-complement wrap.
module echo_tap_scheduler
    import echo_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned NTAPS  = 4
) (
    input  logic                sysclk,
    input  logic                rst_n,
    input  logic                data_valid,
    input  logic [DATA_W-1:0]   sample_in,
    input  logic [DELAY_W-1:0]  delay_sw,
    echo_tap_scheduler_if.master ram,
    output logic [DATA_W-1:0]   y_out,
    output logic                y_valid,
    output logic                busy,
    output logic                overrun
);
`ifdef ECHO_SATURATE_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif
    localparam int unsigned ACC_W  = DATA_W + ACC_EXTRA;
    localparam int unsigned DIST_W = 17;
    localparam int unsigned K_W    = 4;
    localparam int unsigned CNT_W  = ADDR_W + 1;

    logic strobe;

    echo_strobe_det u_strobe (
        .clk      (sysclk),
        .rst_n    (rst_n),
        .async_i  (data_valid),
        .strobe_o (strobe)
    );

    state_e                    state_q, state_d;
    logic [K_W-1:0]            k_q, k_d;
    logic [DATA_W-1:0]         x_q, x_d;
    logic [DELAY_W-1:0]        d_q, d_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [ADDR_W-1:0]         wptr_q, wptr_d;
    logic [DIST_W-1:0]         dist_q, dist_d;
    logic [CNT_W-1:0]          clr_q, clr_d;
    logic                      pend_q, pend_d;
    logic [K_W-1:0]            pend_idx_q, pend_idx_d;
    logic                      pend_keep_q, pend_keep_d;
    logic [ADDR_W-1:0]         raddr_q, raddr_d;
    logic [ADDR_W-1:0]         waddr_q, waddr_d;
    logic                      we_q, we_d;
    logic [DATA_W-2:0]         wdata_q, wdata_d;
    logic [DATA_W-1:0]         y_q, y_d;
    logic                      y_valid_q, y_valid_d;
    logic                      busy_q, busy_d;
    logic                      overrun_q, overrun_d;

    logic signed [ACC_W-1:0]   rdata_ext_c;
    logic signed [ACC_W-1:0]   tap_term_c;
    logic signed [ACC_W-1:0]   x_ext_c;
    logic signed [ACC_W-1:0]   sum_c;
    logic [DIST_W-1:0]         dist_nx_c;

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        x_d         = x_q;
        d_d         = d_q;
        acc_d       = acc_q;
        wptr_d      = wptr_q;
        dist_d      = dist_q;
        clr_d       = clr_q;
        pend_d      = 1'b0;
        pend_idx_d  = pend_idx_q;
        pend_keep_d = 1'b0;
        raddr_d     = raddr_q;
        waddr_d     = waddr_q;
        we_d        = 1'b0;
        wdata_d     = wdata_q;
        y_d         = y_q;
        y_valid_d   = 1'b0;
        overrun_d   = 1'b0;

        // Tap k weight: (w <<< 1) >>> (k+1), applied to the word returned one cycle after its address.
        rdata_ext_c = ACC_W'($signed(ram.ram_rdata));
        tap_term_c  = (rdata_ext_c <<< 1) >>> (pend_idx_q + K_W'(1));
        dist_nx_c   = dist_q + DIST_W'({d_q, 4'b0000});
        x_ext_c     = ACC_W'($signed(x_q));
        if (pend_q && pend_keep_q) acc_d = acc_q + tap_term_c;
        sum_c       = x_ext_c + acc_d;

        case (state_q)
            S_CLEAR: begin
                if (clr_q[ADDR_W]) begin
                    state_d = S_IDLE;
                end else begin
                    we_d    = 1'b1;
                    waddr_d = ADDR_W'(clr_q);
                    wdata_d = '0;
                    clr_d   = clr_q + CNT_W'(1);
                end
            end
            S_IDLE: begin
                if (strobe) begin
                    x_d     = sample_in;
                    d_d     = delay_sw;
                    acc_d   = '0;
                    k_d     = '0;
                    dist_d  = DIST_W'({delay_sw, 4'b0000});
                    raddr_d = wptr_q - ADDR_W'({delay_sw, 4'b0000});
                    state_d = S_READ;
                end
            end
            S_READ: begin
                pend_d      = 1'b1;
                pend_idx_d  = k_q;
                pend_keep_d = (d_q != '0) && ((dist_q >> ADDR_W) == '0);
                if (k_q == K_W'(NTAPS - 1)) begin
                    state_d = S_DRAIN;
                end else begin
                    k_d     = k_q + K_W'(1);
                    dist_d  = dist_nx_c;
                    raddr_d = wptr_q - ADDR_W'(dist_nx_c);
                end
            end
            S_DRAIN: begin
                y_d       = DATA_W'(fold_sample(32'(sum_c), DATA_W, SAT_EN));
                wdata_d   = y_d[DATA_W-1:1];
                waddr_d   = wptr_q;
                we_d      = 1'b1;
                y_valid_d = 1'b1;
                wptr_d    = wptr_q + ADDR_W'(1);
                state_d   = S_WRITE;
            end
            S_WRITE: state_d = S_IDLE;
            default: state_d = S_CLEAR;
        endcase

        if (strobe && ((state_q == S_READ) || (state_q == S_DRAIN) || (state_q == S_WRITE)))
            overrun_d = 1'b1;
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_CLEAR;
            k_q         <= '0;
            x_q         <= '0;
            d_q         <= '0;
            acc_q       <= '0;
            wptr_q      <= '0;
            dist_q      <= '0;
            clr_q       <= '0;
            pend_q      <= 1'b0;
            pend_idx_q  <= '0;
            pend_keep_q <= 1'b0;
            raddr_q     <= '0;
            waddr_q     <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            y_q         <= '0;
            y_valid_q   <= 1'b0;
            busy_q      <= 1'b1;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            x_q         <= x_d;
            d_q         <= d_d;
            acc_q       <= acc_d;
            wptr_q      <= wptr_d;
            dist_q      <= dist_d;
            clr_q       <= clr_d;
            pend_q      <= pend_d;
            pend_idx_q  <= pend_idx_d;
            pend_keep_q <= pend_keep_d;
            raddr_q     <= raddr_d;
            waddr_q     <= waddr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            y_q         <= y_d;
            y_valid_q   <= y_valid_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
        end
    end

    assign ram.ram_raddr = raddr_q;
    assign ram.ram_waddr = waddr_q;
    assign ram.ram_we    = we_q;
    assign ram.ram_wdata = wdata_q;
    assign y_out         = y_q;
    assign y_valid       = y_valid_q;
    assign busy          = busy_q;
    assign overrun       = overrun_q;
endmodule
